// File: rtl/verificar_pin_if.sv
// +----------------------------------------------------------------------------+
// | verificar_pin_pkg / verificar_pin_if                                       |
// | PIN and setup packet types, plus the bus between assembler side and checker |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package verificar_pin_pkg;
   // digito[3] is the first digit typed; 4'hE marks an empty position
   typedef struct packed {
      logic             status;
      logic [3:0][3:0]  digito;
   } pinPac_t;

   typedef struct packed {
      pinPac_t master_pin;
      pinPac_t pin1;
      pinPac_t pin2;
      pinPac_t pin3;
      pinPac_t pin4;
   } setupPac_t;
endpackage

interface verificar_pin_if;
   import verificar_pin_pkg::*;

   logic       enable;
   pinPac_t    pin_in;
   setupPac_t  data_setup;
   logic       pin_valido;
   logic       master_ok;
   logic       pin_invalido;
   logic       bloqueado;
   logic [2:0] tentativas;
   logic [8:0] bloqueio_restante;

   modport master (
      output enable, pin_in, data_setup,
      input  pin_valido, master_ok, pin_invalido, bloqueado, tentativas, bloqueio_restante
   );

   modport slave (
      input  enable, pin_in, data_setup,
      output pin_valido, master_ok, pin_invalido, bloqueado, tentativas, bloqueio_restante
   );
endinterface

`default_nettype wire

// File: rtl/verificar_pin.sv
// +----------------------------------------------------------------------------+
// | verificar_pin                                                              |
// | Checks submitted PINs against master/user slots, counts failures, locks out |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module verificar_pin #(
   parameter int MAX_TENTATIVAS  = 5,
   parameter int BLOQUEIO_CICLOS = 300
) (
   input  wire logic      clk,
   input  wire logic      rst,
   verificar_pin_if.slave bus
);
   import verificar_pin_pkg::*;

   localparam logic [2:0] c_max_tent = 3'(MAX_TENTATIVAS);
   localparam logic [8:0] c_bloqueio = 9'(BLOQUEIO_CICLOS);
   localparam logic [3:0] c_vazio    = 4'hE;

   typedef enum logic [1:0] {
      OCIOSO    = 2'd0,
      AVALIAR   = 2'd1,
      BLOQUEADO = 2'd2
   } estado_t;

   estado_t         r_estado;
   logic            r_status_d;
   logic [3:0][3:0] r_digitos;
   logic            r_pin_valido;
   logic            r_master_ok;
   logic            r_pin_invalido;
   logic            r_bloqueado;
   logic [2:0]      r_tentativas;
   logic [8:0]      r_restante;

   logic            w_submissao;
   logic [3:0]      w_dig_vazio;
   logic            w_vazio;
   logic            w_master_hit;
   logic [3:0]      w_user_hit;
   logic [2:0]      w_tent_inc;
   pinPac_t         w_slot [4];
   logic            w_unused_master_status;

   assign w_slot[0] = bus.data_setup.pin1;
   assign w_slot[1] = bus.data_setup.pin2;
   assign w_slot[2] = bus.data_setup.pin3;
   assign w_slot[3] = bus.data_setup.pin4;

   // The master slot is always active, so its enable bit is deliberately unused
   assign w_unused_master_status = bus.data_setup.master_pin.status;

   generate
      for (genvar i = 0; i < 4; i++) begin : g_slot
         assign w_dig_vazio[i] = (r_digitos[i] == c_vazio);
         assign w_user_hit[i]  = w_slot[i].status && (w_slot[i].digito == r_digitos);
      end
   endgenerate

   assign w_submissao  = bus.pin_in.status & ~r_status_d;
   assign w_vazio      = |w_dig_vazio;
   assign w_master_hit = ~w_vazio && (bus.data_setup.master_pin.digito == r_digitos);
   assign w_tent_inc   = r_tentativas + 3'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_estado       <= OCIOSO;
         r_status_d     <= 1'b0;
         r_digitos      <= {4{c_vazio}};
         r_pin_valido   <= 1'b0;
         r_master_ok    <= 1'b0;
         r_pin_invalido <= 1'b0;
         r_bloqueado    <= 1'b0;
         r_tentativas   <= 3'd0;
         r_restante     <= 9'd0;
      end else begin
         // Edge detector keeps tracking in every state, including lockout
         r_status_d     <= bus.pin_in.status;
         r_pin_valido   <= 1'b0;
         r_master_ok    <= 1'b0;
         r_pin_invalido <= 1'b0;

         case (r_estado)
            OCIOSO: begin
               if (w_submissao && bus.enable) begin
                  r_digitos <= bus.pin_in.digito;
                  r_estado  <= AVALIAR;
               end
            end

            AVALIAR: begin
               if (w_master_hit) begin
                  r_master_ok  <= 1'b1;
                  r_tentativas <= 3'd0;
                  r_estado     <= OCIOSO;
               end else if (~w_vazio && (|w_user_hit)) begin
                  r_pin_valido <= 1'b1;
                  r_tentativas <= 3'd0;
                  r_estado     <= OCIOSO;
               end else begin
                  r_pin_invalido <= 1'b1;
                  r_tentativas   <= w_tent_inc;
                  if (w_tent_inc == c_max_tent) begin
                     r_bloqueado <= 1'b1;
                     r_restante  <= c_bloqueio;
                     r_estado    <= BLOQUEADO;
                  end else begin
                     r_estado    <= OCIOSO;
                  end
               end
            end

            BLOQUEADO: begin
               r_restante <= r_restante - 9'd1;
               if (r_restante == 9'd1) begin
                  r_bloqueado  <= 1'b0;
                  r_tentativas <= 3'd0;
                  r_estado     <= OCIOSO;
               end
            end

            default: r_estado <= OCIOSO;
         endcase
      end
   end

   assign bus.pin_valido        = r_pin_valido;
   assign bus.master_ok         = r_master_ok;
   assign bus.pin_invalido      = r_pin_invalido;
   assign bus.bloqueado         = r_bloqueado;
   assign bus.tentativas        = r_tentativas;
   assign bus.bloqueio_restante = r_restante;

endmodule

`default_nettype wire

// File: tb/tb_verificar_pin.sv
// +----------------------------------------------------------------------------+
// | tb_verificar_pin                                                           |
// | Directed stimulus with a timeline model of outcomes, failures and lockout   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_verificar_pin;
   import verificar_pin_pkg::*;

   localparam int MAXT = 3;
   localparam int BLOQ = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_err    = 0;

   verificar_pin_if bus ();

   verificar_pin #(.MAX_TENTATIVAS(MAXT), .BLOQUEIO_CICLOS(BLOQ)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // ---------------- model: events placed on a cycle timeline ----------------
   int          cyc, eval_at, pulse_cyc, pulse_kind, fails, lock_start, lock_end;
   logic        prev;
   logic [15:0] cap;
   bit          compare_on = 1'b0;

   task automatic model_reset();
      cyc = 0; eval_at = -1; pulse_cyc = -1; pulse_kind = 0; fails = 0;
      lock_start = -1; lock_end = -1; prev = 1'b0; cap = 16'hEEEE;
   endtask

   // 2 = master, 1 = user slot, 0 = nothing
   function automatic int classify(input logic [15:0] d, input setupPac_t su);
      pinPac_t s4 [4];
      for (int i = 0; i < 4; i++) if (d[i*4 +: 4] == 4'hE) return 0;
      if (d == su.master_pin.digito) return 2;
      s4 = '{su.pin1, su.pin2, su.pin3, su.pin4};
      for (int i = 0; i < 4; i++) if (s4[i].status && s4[i].digito == d) return 1;
      return 0;
   endfunction

   task automatic model_step();
      logic s;
      cyc++;
      s = bus.pin_in.status;
      if (cyc == eval_at) begin
         pulse_cyc  = cyc;
         pulse_kind = classify(cap, bus.data_setup);
         if (pulse_kind == 0) begin
            fails++;
            if (fails == MAXT) begin lock_start = cyc; lock_end = cyc + BLOQ; end
         end else fails = 0;
      end else if (cyc > lock_start && cyc <= lock_end) begin
         if (cyc == lock_end) fails = 0;
      end else if (s && !prev && bus.enable) begin
         eval_at = cyc + 1;
         cap     = bus.pin_in.digito;
      end
      prev = s;
   endtask

   initial forever begin
      @(posedge clk);
      if (!rst) model_step();
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (compare_on) begin
         int  k;
         bit  lk;
         k  = (pulse_cyc == cyc) ? pulse_kind : -1;
         lk = (cyc >= lock_start && cyc < lock_end);
         chk("mdl_pin_valido",   bus.pin_valido,   (k == 1) ? 1 : 0);
         chk("mdl_master_ok",    bus.master_ok,    (k == 2) ? 1 : 0);
         chk("mdl_pin_invalido", bus.pin_invalido, (k == 0) ? 1 : 0);
         chk("mdl_bloqueado",    bus.bloqueado,    lk ? 1 : 0);
         chk("mdl_restante",     bus.bloqueio_restante, lk ? (lock_end - cyc) : 0);
         chk("mdl_tentativas",   bus.tentativas,   fails);
      end
   end

   // ---------------- directed stimulus with literal expectations ----------------
   // kind: 0 none, 1 pin_valido, 2 master_ok, 3 pin_invalido
   task automatic submit(input logic [15:0] d, input int hold, input int kind,
                         input int tent, input int bloq);
      @(negedge clk);
      bus.pin_in.digito = d;
      bus.pin_in.status = 1'b1;
      for (int i = 1; i <= hold + 2; i++) begin
         @(negedge clk);
         if (i == hold) begin bus.pin_in.status = 1'b0; bus.pin_in.digito = 16'hEEEE; end
         if (i == 2) begin
            chk("lit_valido",   bus.pin_valido,   (kind == 1) ? 1 : 0);
            chk("lit_master",   bus.master_ok,    (kind == 2) ? 1 : 0);
            chk("lit_invalido", bus.pin_invalido, (kind == 3) ? 1 : 0);
            chk("lit_tent",     bus.tentativas,   tent);
            chk("lit_bloq",     bus.bloqueado,    bloq);
         end
         if (i == 3)
            chk("lit_one_cycle", bus.pin_valido | bus.master_ok | bus.pin_invalido, 0);
      end
   endtask

   initial begin
      model_reset();
      bus.enable                    = 1'b1;
      bus.pin_in                    = '{status: 1'b0, digito: 16'hEEEE};
      bus.data_setup.master_pin     = '{status: 1'b0, digito: 16'h9999};
      bus.data_setup.pin1           = '{status: 1'b1, digito: 16'h1234};
      bus.data_setup.pin2           = '{status: 1'b1, digito: 16'h9999};
      bus.data_setup.pin3           = '{status: 1'b0, digito: 16'h5555};
      bus.data_setup.pin4           = '{status: 1'b0, digito: 16'h0000};
      repeat (2) @(negedge clk);
      chk("rst_bloq", bus.bloqueado, 0);
      chk("rst_rest", bus.bloqueio_restante, 0);
      chk("rst_tent", bus.tentativas, 0);
      chk("rst_pulses", bus.pin_valido | bus.master_ok | bus.pin_invalido, 0);
      rst = 1'b0;
      compare_on = 1'b1;

      submit(16'h1234, 2, 1, 0, 0);   // user slot 1
      submit(16'h9999, 2, 2, 0, 0);   // master wins over pin2
      submit(16'h5555, 2, 3, 1, 0);   // slot disabled
      submit(16'h1234, 3, 1, 0, 0);   // success clears count
      submit(16'h12EE, 2, 3, 1, 0);   // partial PIN
      bus.enable = 1'b0;
      submit(16'h1234, 2, 0, 1, 0);   // ignored while disabled
      bus.enable = 1'b1;
      submit(16'h4321, 5, 3, 2, 0);   // long hold, single evaluation
      submit(16'h7777, 2, 3, 3, 1);   // third failure locks
      submit(16'h1234, 2, 0, 3, 1);   // ignored while locked

      // Hold status across lockout exit: must not count as a new submission
      @(negedge clk);
      bus.pin_in.digito = 16'h1234;
      bus.pin_in.status = 1'b1;
      repeat (6) @(negedge clk);
      bus.pin_in.status = 1'b0;
      @(negedge clk);
      chk("unlock_bloq", bus.bloqueado, 0);
      chk("unlock_tent", bus.tentativas, 0);
      submit(16'h1234, 2, 1, 0, 0);

      submit(16'h5555, 2, 3, 1, 0);
      submit(16'h4321, 2, 3, 2, 0);
      submit(16'h7777, 2, 3, 3, 1);
      begin
         int n = 0;
         while (bus.bloqueio_restante != 9'd4 && n < 40) begin @(negedge clk); n++; end
         chk("wait_rest4_timeout", (n < 40) ? 1 : 0, 1);
      end
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("async_rst_bloq", bus.bloqueado, 0);
      chk("async_rst_rest", bus.bloqueio_restante, 0);
      chk("async_rst_tent", bus.tentativas, 0);
      @(negedge clk);
      rst = 1'b0;
      submit(16'h9999, 2, 2, 0, 0);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
